// File: rtl/dm_abstract_ctrl.sv
// Abstract-command sequencer: decodes DMI command writes, selects the debug-ROM
// routine and fix-up field, handshakes with the halted hart and owns busy/cmderr.
module dm_abstract_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   input  logic [31:0] cmd,
   input  logic [2:0]  cmderr_clr,
   input  logic        hart_halted,
   input  logic        hart_going,
   input  logic        hart_done,
   input  logic        hart_exception,
   output logic        go,
   output logic [2:0]  cmd_sel,
   output logic [11:0] instr_fix,
   output logic        busy,
   output logic [2:0]  cmderr
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, GO, WAIT} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;

   logic [7:0]  cmdtype;
   logic [2:0]  size;
   logic        transfer, write, is_reg, is_mem, is_gpr, is_csr, cmd_bad;
   logic [15:0] regno;

   always_comb begin
      cmdtype  = cmd[31:24];
      size     = cmd[22:20];
      transfer = cmd[17];
      write    = cmd[16];
      regno    = cmd[15:0];
      is_reg   = (cmdtype == 8'd0);
      is_mem   = (cmdtype == 8'd2);
      is_gpr   = (regno[15:5] == 11'h080);
      is_csr   = (regno[15:12] == 4'h0);
      cmd_bad  = !(is_reg || is_mem)
               || (is_reg && cmd[18])
               || (is_mem && cmd[19])
               || (is_reg && transfer && size != 3'd2)
               || (is_mem && size > 3'd2)
               || (is_reg && transfer && !is_gpr && !is_csr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         go        <= 1'b0;
         cmd_sel   <= '0;
         instr_fix <= '0;
         busy      <= 1'b0;
         cmderr    <= '0;
      end else begin
         // W1C clear; any error raised below in this cycle overwrites it
         cmderr <= cmderr & ~cmderr_clr;
         if (cmd_valid && busy && cmderr == 3'd0)
            cmderr <= 3'd1;
         case (state)
            IDLE: begin
               // busy high in IDLE only for the single cycle of a transfer=0 command
               busy <= 1'b0;
               if (cmd_valid && !busy && cmderr == 3'd0) begin
                  if (!hart_halted)
                     cmderr <= 3'd4;
                  else if (cmd_bad)
                     cmderr <= 3'd2;
                  else if (is_reg && !transfer)
                     busy <= 1'b1;
                  else begin
                     if (is_mem) begin
                        instr_fix <= {9'b0, size};
                        cmd_sel   <= write ? 3'd4 : 3'd5;
                     end else if (is_gpr) begin
                        instr_fix <= {7'b0, regno[4:0]};
                        cmd_sel   <= write ? 3'd0 : 3'd1;
                     end else begin
                        instr_fix <= regno[11:0];
                        cmd_sel   <= write ? 3'd2 : 3'd3;
                     end
                     busy  <= 1'b1;
                     go    <= 1'b1;
                     cnt   <= '0;
                     state <= GO;
                  end
               end
            end
            GO: begin
               cnt <= cnt + 1'b1;
               if (hart_going) begin
                  go  <= 1'b0;
                  cnt <= '0;
                  if (hart_exception) begin
                     cmderr <= 3'd3;
                     busy   <= 1'b0;
                     state  <= IDLE;
                  end else if (hart_done) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else
                     state <= WAIT;
               end else if (cnt == CNT_MAX) begin
                  cmderr <= 3'd3;
                  busy   <= 1'b0;
                  go     <= 1'b0;
                  state  <= IDLE;
               end
            end
            WAIT: begin
               cnt <= cnt + 1'b1;
               if (hart_exception || cnt == CNT_MAX) begin
                  cmderr <= 3'd3;
                  busy   <= 1'b0;
                  go     <= 1'b0;
                  state  <= IDLE;
               end else if (hart_done) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_abstract_ctrl.sv
// Directed bench for dm_abstract_ctrl with hand-computed expectations (TIMEOUT_CYCLES=8).
module tb_dm_abstract_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic [31:0] cmd;
   logic [2:0]  cmderr_clr;
   logic        hart_halted, hart_going, hart_done, hart_exception;
   logic        go;
   logic [2:0]  cmd_sel;
   logic [11:0] instr_fix;
   logic        busy;
   logic [2:0]  cmderr;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   dm_abstract_ctrl #(.TIMEOUT_CYCLES(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_valid      (cmd_valid),
      .cmd            (cmd),
      .cmderr_clr     (cmderr_clr),
      .hart_halted    (hart_halted),
      .hart_going     (hart_going),
      .hart_done      (hart_done),
      .hart_exception (hart_exception),
      .go             (go),
      .cmd_sel        (cmd_sel),
      .instr_fix      (instr_fix),
      .busy           (busy),
      .cmderr         (cmderr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int unsigned n = 1);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [31:0] c);
      cmd_valid = 1'b1;
      cmd       = c;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic pulse(input logic g, input logic d, input logic e);
      hart_going     = g;
      hart_done      = d;
      hart_exception = e;
      tick();
      hart_going     = 1'b0;
      hart_done      = 1'b0;
      hart_exception = 1'b0;
   endtask

   task automatic clear_err();
      cmderr_clr = 3'b111;
      tick();
      cmderr_clr = 3'b000;
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd = '0; cmderr_clr = '0;
      hart_halted = 1'b1; hart_going = 1'b0; hart_done = 1'b0; hart_exception = 1'b0;
      tick(2);
      check("rst_busy", busy, 0);
      check("rst_go", go, 0);
      check("rst_cmderr", cmderr, 0);
      check("rst_sel", cmd_sel, 0);
      check("rst_fix", instr_fix, 0);
      rst = 1'b0;
      tick();

      // GPR write x5
      send(32'h00231005);
      check("gpr_busy", busy, 1);
      check("gpr_go", go, 1);
      check("gpr_sel", cmd_sel, 0);
      check("gpr_fix", instr_fix, 12'h005);
      pulse(1, 0, 0);
      check("gpr_going_go", go, 0);
      check("gpr_going_busy", busy, 1);
      tick(2);
      pulse(0, 1, 0);
      check("gpr_done_busy", busy, 0);
      check("gpr_done_err", cmderr, 0);

      // CSR read mstatus; going+done together completes at once
      send(32'h00220300);
      check("csr_sel", cmd_sel, 3);
      check("csr_fix", instr_fix, 12'h300);
      pulse(1, 1, 0);
      check("csr_gd_busy", busy, 0);
      check("csr_gd_go", go, 0);

      send(32'h02210000);
      check("memw_sel", cmd_sel, 4);
      check("memw_fix", instr_fix, 12'h002);
      pulse(1, 0, 0);
      pulse(0, 1, 0);
      check("memw_busy", busy, 0);

      send(32'h02000000);
      check("memr_sel", cmd_sel, 5);
      check("memr_fix", instr_fix, 12'h000);
      pulse(1, 0, 0);
      pulse(0, 1, 0);

      // unsupported aarsize
      send(32'h00331005);
      check("size_err", cmderr, 2);
      check("size_busy", busy, 0);
      check("size_go", go, 0);
      send(32'h00231005);
      check("ign_busy", busy, 0);
      check("ign_err", cmderr, 2);
      check("ign_sel", cmd_sel, 5);
      clear_err();
      check("clr_err", cmderr, 0);
      send(32'h0023101F);
      check("x31_busy", busy, 1);
      check("x31_sel", cmd_sel, 0);
      check("x31_fix", instr_fix, 12'h01F);
      pulse(1, 1, 0);

      // regno just past the GPR window
      send(32'h00231020);
      check("regno_err", cmderr, 2);
      check("regno_busy", busy, 0);
      clear_err();

      hart_halted = 1'b0;
      send(32'h00231005);
      check("halt_err", cmderr, 4);
      check("halt_busy", busy, 0);
      hart_halted = 1'b1;
      clear_err();

      // second command while busy
      send(32'h00231005);
      pulse(1, 0, 0);
      send(32'h00220300);
      check("busy_err", cmderr, 1);
      check("busy_still", busy, 1);
      check("busy_sel_kept", cmd_sel, 0);
      pulse(0, 1, 0);
      check("busy_done", busy, 0);
      check("busy_err_kept", cmderr, 1);
      clear_err();

      // timeout from WAIT: 8 cycles after entering WAIT
      send(32'h00231005);
      pulse(1, 0, 0);
      tick(7);
      check("to_w_busy7", busy, 1);
      tick();
      check("to_w_busy8", busy, 0);
      check("to_w_err", cmderr, 3);
      check("to_w_go", go, 0);
      cmderr_clr = 3'b001;
      tick();
      cmderr_clr = 3'b000;
      check("partial_clr", cmderr, 2);
      clear_err();

      // timeout while the hart never takes the routine
      send(32'h00231005);
      tick(7);
      check("to_g_go7", go, 1);
      tick();
      check("to_g_busy", busy, 0);
      check("to_g_go", go, 0);
      check("to_g_err", cmderr, 3);
      clear_err();

      // exception beats done
      send(32'h00231005);
      pulse(1, 0, 0);
      pulse(0, 1, 1);
      check("exc_err", cmderr, 3);
      check("exc_busy", busy, 0);
      clear_err();

      // reset while in GO
      send(32'h00220300);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstgo_go", go, 0);
      check("rstgo_busy", busy, 0);
      check("rstgo_err", cmderr, 0);
      check("rstgo_sel", cmd_sel, 0);

      // transfer=0: one-cycle busy, no go
      send(32'h00200000);
      check("nop_busy1", busy, 1);
      check("nop_go", go, 0);
      tick();
      check("nop_busy0", busy, 0);
      check("nop_err", cmderr, 0);

      // handshake pulses ignored in IDLE
      pulse(1, 1, 1);
      check("idle_pulse_err", cmderr, 0);
      check("idle_pulse_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dm_abstract_ctrl.md
Name: dm_abstract_ctrl

Overview:
Abstract-command sequencer for the debug module.
- Accepts the DMI `command` register write and decodes access-register or access-memory commands.
- Selects the debug-ROM routine and drives the 12-bit instruction fix-up field into the debug ROM.
- Handshakes with the halted hart running the ROM park loop, and owns `abstractcs.busy` and `abstractcs.cmderr`, including the abort timeout.

Parameters:
TIMEOUT_CYCLES, 4096, cycles in WAIT before a command is aborted with cmderr=3; minimum 2.

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  one-cycle pulse: DMI write to `command`
cmd  input  32  command value; sampled only when cmd_valid=1
cmderr_clr  input  3  W1C mask from a DMI write to `abstractcs`; valid only in that cycle
hart_halted  input  1  hart is in debug mode
hart_going  input  1  pulse: hart has left the park loop and taken the routine
hart_done  input  1  pulse: routine completed
hart_exception  input  1  pulse: exception inside the routine
go  output  1  request to the hart to execute the routine
cmd_sel  output  3  routine: 0 SET_GPR, 1 GET_GPR, 2 SET_CSR, 3 GET_CSR, 4 SET_MEM, 5 GET_MEM
instr_fix  output  12  fix-up field driven into the debug ROM
busy  output  1  abstractcs.busy
cmderr  output  3  abstractcs.cmderr

Behaviour:
- Reset: go=0, cmd_sel=0, instr_fix=0, busy=0, cmderr=0, state=IDLE, timeout counter=0. Reset in any state aborts the command; no error is recorded.
- States: IDLE, GO, WAIT. All outputs are registered.
- Decode in IDLE, when cmd_valid=1 and cmderr==0:
  - cmdtype = cmd[31:24].
  - Access register (cmdtype 0): aarsize = [22:20], postexec = [18], transfer = [17], write = [16], regno = [15:0].
  - Access memory (cmdtype 2): aamsize = [22:20], aampostincrement = [19], write = [16].
- Error checks, first match wins:
  - hart_halted=0 → cmderr=4.
  - Any of the following → cmderr=2:
    - cmdtype not 0 or 2;
    - postexec=1 or aampostincrement=1;
    - access-register with transfer=1 and aarsize≠2;
    - access-memory with aamsize>2;
    - transfer=1 with regno outside 0x0000–0x0FFF and 0x1000–0x101F.
  - On any error: stay in IDLE, busy stays 0.
- Valid commands, outputs registered at the next edge:
  - transfer=0 access-register: busy=1 for exactly one cycle, then busy=0 and return to IDLE. go is never asserted.
  - GPR (regno 0x1000–0x101F): instr_fix = {7'b0, regno[4:0]}; cmd_sel = write ? 0 : 1.
  - CSR (regno 0x000–0xFFF): instr_fix = regno[11:0]; cmd_sel = write ? 2 : 3.
  - Memory: instr_fix = {9'b0, aamsize}; cmd_sel = write ? 4 : 5.
  - busy=1, go=1, state=GO.
- cmd_sel and instr_fix hold their values until the next accepted command; they are not cleared on completion.
- GO: hold go=1 until hart_going, then go=0 and state=WAIT with the counter cleared. A hart_going in the same cycle as hart_done is treated as going followed by done, so the command completes directly.
- WAIT: the counter increments each cycle.
  - hart_done → busy=0, IDLE.
  - hart_exception → cmderr=3, busy=0, IDLE. If done and exception arrive together, exception wins.
  - Counter reaching TIMEOUT_CYCLES-1 → cmderr=3, busy=0, go=0, IDLE.
  - The counter also runs in GO, so a hart that never responds still times out.
- cmd_valid while busy=1: if cmderr==0, set cmderr=1. The command is ignored and the running command is unaffected.
- cmd_valid while cmderr≠0: ignored, no state change.
- cmderr update each cycle: cmderr_next = cmderr & ~cmderr_clr, except that a new error raised in the same cycle overwrites it. The command check uses the registered cmderr, not the cleared value.
- hart_going, hart_done and hart_exception pulses are ignored in IDLE.

Test Plan:
- Halted hart; cmd=0x00231005 (write x5) → next cycle busy=1, go=1, cmd_sel=0, instr_fix=0x005. Pulse hart_going → go=0. Pulse hart_done 3 cycles later → busy=0, cmderr=0.
- cmd=0x00220300 (read mstatus) → cmd_sel=3, instr_fix=0x300. cmd=0x02210000 (memory word write) → cmd_sel=4, instr_fix=0x002. cmd=0x02000000 (memory byte read) → cmd_sel=5, instr_fix=0x000.
- cmd=0x00331005 (aarsize=3) → cmderr=2, busy=0, go never set. Next cmd is ignored. cmderr_clr=3'b111 → cmderr=0, and a following valid cmd is accepted.
- hart_halted=0, cmd=0x00231005 → cmderr=4. During WAIT, a second cmd_valid → cmderr=1; a later hart_done still clears busy.
- TIMEOUT_CYCLES=8: accepted cmd, hart_going, no done → cmderr=3 and busy=0 exactly 8 cycles after entering WAIT. Also, hart_exception and hart_done in the same cycle → cmderr=3.
- rst asserted in GO → next cycle go=0, busy=0, cmderr=0, IDLE. cmd=0x00200000 (transfer=0) → busy high for exactly one cycle.
